// File: rtl/multiplier_ctrl_v1_if.sv
// Request/response handshake bundle for the RV32M multiplier controller.
// slave = controller side, master = issuing pipeline side.
interface multiplier_ctrl_v1_if;
    logic       req_valid_i;
    logic [2:0] req_funct3_i;
    logic       req_ready_o;
    logic       resp_valid_o;
    logic       resp_ready_i;
    logic       kill_i;
    logic       busy_o;

    modport slave (
        input  req_valid_i,
        input  req_funct3_i,
        input  resp_ready_i,
        input  kill_i,
        output req_ready_o,
        output resp_valid_o,
        output busy_o
    );

    modport master (
        output req_valid_i,
        output req_funct3_i,
        output resp_ready_i,
        output kill_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  busy_o
    );
endinterface

// File: rtl/multiplier_ctrl_v1.sv
// Sequencer for a byte-serial 32x8 multiplier datapath (RV32M MUL/MULH*).
// Four accumulate cycles, one pipeline drain, then a held response.
module multiplier_ctrl_v1 (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    multiplier_ctrl_v1_if.slave         bus,
    output logic                        reg_A_en_o,
    output logic                        reg_B_en_o,
    output logic                        AC_en_o,
    output logic                        en_pipe_o,
    output logic                        mux_B_sel_o,
    output logic                        signed_A_o,
    output logic                        signed_B_o,
    output logic                        rol_en_o,
    output logic                        upper_o,
    output logic                        ac_clr_o,
    output logic [1:0]                  shift_amount_o
);

    typedef enum logic [2:0] {
        IDLE, C0, C1, C2, C3, DRAIN, DONE
    } state_e;

    state_e     state_q, state_d;
    logic       accept;
    logic [2:0] f3;
    logic       reg_B_en_q, AC_en_q, en_pipe_q;
    logic       mux_B_sel_q, rol_en_q;
    logic       resp_valid_q, busy_q;
    logic [1:0] shift_q;

    assign f3 = bus.req_funct3_i;
    assign bus.req_ready_o = (state_q == IDLE) && !f3[2];
    assign accept = bus.req_valid_i && bus.req_ready_o;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = C0;
            C0:      state_d = C1;
            C1:      state_d = C2;
            C2:      state_d = C3;
            C3:      state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (bus.resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.kill_i && (state_q != IDLE)) state_d = IDLE;
    end

    // Per-state controls are decoded from the next state so they are registered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            reg_B_en_q   <= 1'b0;
            AC_en_q      <= 1'b0;
            en_pipe_q    <= 1'b0;
            mux_B_sel_q  <= 1'b0;
            rol_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            shift_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            reg_B_en_q   <= 1'b0;
            AC_en_q      <= 1'b0;
            en_pipe_q    <= 1'b0;
            mux_B_sel_q  <= 1'b0;
            rol_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            shift_q      <= 2'b00;
            busy_q       <= (state_d != IDLE);
            unique case (state_d)
                C0, C1, C2: begin
                    en_pipe_q   <= 1'b1;
                    AC_en_q     <= 1'b1;
                    reg_B_en_q  <= 1'b1;
                    mux_B_sel_q <= 1'b1;
                    rol_en_q    <= 1'b1;
                end
                C3: begin
                    en_pipe_q <= 1'b1;
                    AC_en_q   <= 1'b1;
                end
                DRAIN:   en_pipe_q    <= 1'b1;
                DONE:    resp_valid_q <= 1'b1;
                default: ;
            endcase
            unique case (state_d)
                C1:      shift_q <= 2'b01;
                C2:      shift_q <= 2'b11;
                C3:      shift_q <= 2'b10;
                default: shift_q <= 2'b00;
            endcase
        end
    end

    assign reg_A_en_o     = accept;
    assign reg_B_en_o     = accept | reg_B_en_q;
    assign ac_clr_o       = accept;
    assign upper_o        = accept && (f3 != 3'b000);
    assign signed_A_o     = accept && ((f3 == 3'b001) || (f3 == 3'b010));
    assign signed_B_o     = accept && (f3 == 3'b001);
    assign AC_en_o        = AC_en_q;
    assign en_pipe_o      = en_pipe_q;
    assign mux_B_sel_o    = mux_B_sel_q;
    assign rol_en_o       = rol_en_q;
    assign shift_amount_o = shift_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_multiplier_ctrl_v1.sv
// Bench for multiplier_ctrl_v1: control-sequence checks plus a byte-serial
// datapath model driven by the controller, results scored against a golden multiply.
module tb_multiplier_ctrl_v1;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    initial forever #5 clk_i = ~clk_i;

    multiplier_ctrl_v1_if mif();

    logic       reg_A_en, reg_B_en, AC_en, en_pipe, mux_B_sel;
    logic       signed_A, signed_B, rol_en, upper, ac_clr;
    logic [1:0] shift;

    multiplier_ctrl_v1 dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bus            (mif),
        .reg_A_en_o     (reg_A_en),
        .reg_B_en_o     (reg_B_en),
        .AC_en_o        (AC_en),
        .en_pipe_o      (en_pipe),
        .mux_B_sel_o    (mux_B_sel),
        .signed_A_o     (signed_A),
        .signed_B_o     (signed_B),
        .rol_en_o       (rol_en),
        .upper_o        (upper),
        .ac_clr_o       (ac_clr),
        .shift_amount_o (shift)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [31:0] sb[$];

    always_ff @(posedge clk_i) cyc <= cyc + 1;

    // Datapath model: 32-bit A times one B byte per cycle, one pipe stage.
    logic [31:0] opa, opb, b_q, result;
    logic [63:0] a_q, pp_q, acc_q;
    logic        ace_q, sb_q, up_q;

    function automatic int kdec(logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [63:0] bval(logic [7:0] by, logic sg);
        return sg ? {{56{by[7]}}, by} : {56'b0, by};
    endfunction

    always_ff @(posedge clk_i) begin
        if (reg_A_en) begin
            a_q  <= signed_A ? {{32{opa[31]}}, opa} : {32'b0, opa};
            sb_q <= signed_B;
            up_q <= upper;
        end
        if (reg_B_en)
            b_q <= !mux_B_sel ? opb : (rol_en ? {b_q[7:0], b_q[31:8]} : b_q);
        if (en_pipe) begin
            pp_q  <= (a_q * bval(b_q[7:0], sb_q && (shift == 2'b10)))
                     << (8 * kdec(shift));
            ace_q <= AC_en;
        end
        if (ac_clr) acc_q <= 64'b0;
        else if (en_pipe && ace_q) acc_q <= acc_q + pp_q;
    end

    assign result = up_q ? acc_q[63:32] : acc_q[31:0];

    function automatic logic [31:0] ref_mul(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        xb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p = xa * xb;
        return (f == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [13:0] ctrl_now();
        return {reg_A_en, reg_B_en, AC_en, en_pipe, mux_B_sel, signed_A,
                signed_B, rol_en, upper, ac_clr, shift,
                mif.resp_valid_o, mif.busy_o};
    endfunction

    function automatic logic [13:0] exp_acc(logic [2:0] f);
        logic sa, sbv, up;
        sa = (f == 3'd1) || (f == 3'd2);
        sbv = (f == 3'd1);
        up = (f != 3'd0);
        return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, sa, sbv, 1'b0, up, 1'b1,
                2'b00, 1'b0, 1'b0};
    endfunction

    function automatic logic [13:0] exp_stage(int n);
        case (n)
            1:       return 14'b0_1_1_1_1_0_0_1_0_0_00_0_1;
            2:       return 14'b0_1_1_1_1_0_0_1_0_0_01_0_1;
            3:       return 14'b0_1_1_1_1_0_0_1_0_0_11_0_1;
            4:       return 14'b0_0_1_1_0_0_0_0_0_0_10_0_1;
            5:       return 14'b0_0_0_1_0_0_0_0_0_0_00_0_1;
            6:       return 14'b0_0_0_0_0_0_0_0_0_0_00_1_1;
            default: return 14'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold,
                          input bit kill_acc, input bit b2b);
        int n;
        logic [31:0] want, first;
        opa = a;
        opb = b;
        mif.req_funct3_i = f;
        mif.req_valid_i = 1'b1;
        mif.kill_i = kill_acc;
        mif.resp_ready_i = (hold == 0);
        #4;
        chk("accept_ready", mif.req_ready_o, 1'b1);
        chk("accept_ctrl", ctrl_now(), exp_acc(f));
        if (b2b) chk("issue_rate", cyc - last_acc, 7);
        last_acc = cyc;
        sb.push_back(exp);
        @(posedge clk_i); #1;
        mif.req_valid_i = 1'b0;
        mif.kill_i = 1'b0;
        for (n = 1; n <= 15; n++) begin
            #4;
            if (mif.resp_valid_o) break;
            if (n <= 5) chk($sformatf("stage%0d_ctrl", n), ctrl_now(), exp_stage(n));
            @(posedge clk_i); #1;
        end
        chk("latency", n, 6);
        want = sb.pop_front();
        if (!mif.resp_valid_o) begin
            mif.resp_ready_i = 1'b0;
            return;
        end
        chk("done_ctrl", ctrl_now(), exp_stage(6));
        chk("result", result, want);
        first = result;
        if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                @(posedge clk_i); #5;
                chk("hold_valid", mif.resp_valid_o, 1'b1);
                chk("hold_result", result, first);
            end
            @(posedge clk_i); #1;
            mif.resp_ready_i = 1'b1;
            #4;
            chk("release_valid", mif.resp_valid_o, 1'b1);
            chk("release_result", result, first);
        end
        @(posedge clk_i); #1;
        mif.resp_ready_i = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t tv[11];

    initial begin
        tv[0]  = '{3'd0, 32'd7,          32'd6,          32'd42,         0};
        tv[1]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   0};
        tv[2]  = '{3'd2, 32'h80000000,   32'h00000002,   32'hFFFFFFFF,   5};
        tv[3]  = '{3'd3, 32'hFFFFFFFF,   32'h00000002,   32'h00000001,   0};
        tv[4]  = '{3'd1, 32'h80000000,   32'h80000000,   32'h40000000,   0};
        tv[5]  = '{3'd3, 32'h80000000,   32'h80000000,   32'h40000000,   2};
        tv[6]  = '{3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   0};
        tv[7]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   0};
        tv[8]  = '{3'd1, 32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF,   0};
        tv[9]  = '{3'd0, 32'h00010000,   32'h00010000,   32'h00000000,   0};
        tv[10] = '{3'd3, 32'h00010000,   32'h00010000,   32'h00000001,   1};

        mif.req_valid_i = 1'b0;
        mif.req_funct3_i = 3'd0;
        mif.resp_ready_i = 1'b0;
        mif.kill_i = 1'b0;
        opa = 32'd0;
        opb = 32'd0;

        repeat (2) @(posedge clk_i);
        #5;
        chk("reset_ctrl", ctrl_now(), 14'b0);
        chk("reset_ready", mif.req_ready_o, 1'b1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 11; i++)
            run_op(tv[i].f3, tv[i].a, tv[i].b, tv[i].exp, tv[i].hold,
                   i == 3, i > 0 && tv[(i > 0) ? i - 1 : 0].hold == 0);

        // Unsupported funct3 values are never accepted.
        mif.req_valid_i = 1'b1;
        mif.req_funct3_i = 3'b100;
        for (int i = 0; i < 10; i++) begin
            #4;
            chk("div_ready", mif.req_ready_o, 1'b0);
            chk("div_busy", mif.busy_o, 1'b0);
            @(posedge clk_i); #1;
        end
        for (int f = 5; f < 8; f++) begin
            mif.req_funct3_i = 3'(f);
            #4;
            chk("f3hi_ready", mif.req_ready_o, 1'b0);
            @(posedge clk_i); #1;
        end
        mif.req_valid_i = 1'b0;

        // Kill while in C2.
        opa = 32'd9;
        opb = 32'd9;
        mif.req_funct3_i = 3'd0;
        mif.req_valid_i = 1'b1;
        #4;
        chk("kill_accept", mif.req_ready_o, 1'b1);
        @(posedge clk_i); #1;
        mif.req_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        mif.kill_i = 1'b1;
        #4;
        chk("kill_c2_ctrl", ctrl_now(), exp_stage(3));
        @(posedge clk_i); #1;
        mif.kill_i = 1'b0;
        #4;
        chk("kill_idle_ctrl", ctrl_now(), 14'b0);
        chk("kill_idle_ready", mif.req_ready_o, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #5;
            chk("kill_no_resp", mif.resp_valid_o, 1'b0);
        end
        @(posedge clk_i); #1;
        run_op(3'd3, 32'hFFFFFFFF, 32'd2, 32'd1, 0, 1'b0, 1'b0);

        // Reset in the middle of an operation.
        opa = 32'd5;
        opb = 32'd5;
        mif.req_funct3_i = 3'd0;
        mif.req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        mif.req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        #4;
        chk("midrst_ctrl", ctrl_now(), 14'b0);
        chk("midrst_ready", mif.req_ready_o, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #5;
            chk("midrst_no_resp", mif.resp_valid_o, 1'b0);
        end
        @(posedge clk_i); #1;
        run_op(3'd0, 32'd1234, 32'd5678, 32'd7006652, 0, 1'b0, 1'b0);

        // Back-to-back random operations with resp_ready held high.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            logic [2:0]  rf;
            ra = $urandom;
            rb = $urandom;
            rf = 3'($urandom_range(0, 3));
            run_op(rf, ra, rb, ref_mul(rf, ra, rb), 0, 1'b0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
